countdown_timer: RTL and testbench

- Parametrised successor to the fixed 4-digit mm:ss egg timer.
- Programmable N-digit BCD countdown with an internal 1 s prescaler, a start/pause/clear state machine and a latched done/alarm flag.
- Sits between the button front-end (debounced single-cycle pulses) and the seven-segment display mux.
- Its count bus feeds the display; prog/count selection is internal.

---
 rtl/countdown_pkg.sv | 23 ++
 rtl/countdown_timer_if.sv | 25 ++
 rtl/bcd_down_digit.sv | 42 ++++
 rtl/countdown_timer.sv | 168 ++++++++++++++++
 tb/tb_countdown_timer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the N-digit BCD countdown timer.
// Holds the state encoding and the per-digit rollover limit for mm:ss or plain decimal digits.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [3:0] BCD_DEC_MAX  = 4'd9;
    localparam logic [3:0] BCD_TIME_MAX = 4'd5;

    // Odd digits are the tens of seconds/minutes in time format, so they top out at 5.
    function automatic logic [3:0] digit_max(input int idx, input int mmss_mode);
        if (mmss_mode != 0 && idx[0]) begin
            return BCD_TIME_MAX;
        end
        return BCD_DEC_MAX;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Button-side and display-side signals of the countdown timer.
// The front-end/display side uses the master modport; the timer uses slave.
interface countdown_timer_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      start;
    logic                      clear;
    logic                      prog_load;
    logic [4*NUM_DIGITS-1:0]   prog_bcd;
    logic [4*NUM_DIGITS-1:0]   count_bcd;
    logic [1:0]                state;
    logic                      running;
    logic                      done;
    logic                      sec_pulse;

    modport master (
        output start, clear, prog_load, prog_bcd,
        input  count_bcd, state, running, done, sec_pulse
    );

    modport slave (
        input  start, clear, prog_load, prog_bcd,
        output count_bcd, state, running, done, sec_pulse
    );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with parallel load and a rippling borrow chain.
// Wraps 0 -> DIGIT_MAX when borrowed from, and requests a borrow from the next digit up.
module bcd_down_digit #(
    parameter logic [3:0] DIGIT_MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out,
    output logic       is_zero
);

    logic [3:0] digit_q, digit_d;

    assign is_zero    = (digit_q == 4'd0);
    assign borrow_out = borrow_in & is_zero;
    assign digit      = digit_q;

    always_comb begin
        // NOTE: default first so every path assigns digit_d and no latch is inferred.
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (dec_en && borrow_in) begin
            digit_d = is_zero ? DIGIT_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q <= 4'd0;
        end else begin
            // NOTE: non-blocking so all digits update together from pre-edge values.
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Programmable N-digit BCD countdown timer with 1 s prescaler and start/pause/clear FSM.
// Define COUNTDOWN_AUTO_RELOAD_EN for a periodic timer that reloads on expiry instead of stopping.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int TICKS_PER_SEC = 5000000,
    parameter int PRESCALE_W    = 23,
    parameter int MMSS_MODE     = 1
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

    state_e                 state_q, state_d;
    logic [PRESCALE_W-1:0]  presc_q, presc_d;
    logic [CW-1:0]          prog_q, prog_d;
    logic                   running_q, running_d;
    logic                   done_q, done_d;
    logic                   pulse_q, pulse_d;

    logic [CW-1:0]          count;
    logic [CW-1:0]          clamped;
    logic [CW-1:0]          load_val;
    logic [NUM_DIGITS:0]    borrow;
    logic [NUM_DIGITS-1:0]  zero;
    logic                   count_load;
    logic                   dec_en;
    logic                   tick;
    logic                   last_sec;
    logic [1:0]             unused_bits;

    assign tick        = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    // The decrement lands on all zeros exactly when the count currently reads 1.
    assign last_sec    = (count[3:0] == 4'd1) && (&zero[NUM_DIGITS-1:1]);
    assign unused_bits = {borrow[NUM_DIGITS], zero[0]};

    always_comb begin
        clamped = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            clamped[4*i +: 4] = (bus.prog_bcd[4*i +: 4] > digit_max(i, MMSS_MODE))
                              ? digit_max(i, MMSS_MODE) : bus.prog_bcd[4*i +: 4];
        end
    end

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_down_digit #(
            .DIGIT_MAX (digit_max(i, MMSS_MODE))
        ) u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (count_load),
            .load_val   (load_val[4*i +: 4]),
            .dec_en     (dec_en),
            .borrow_in  (borrow[i]),
            .digit      (count[4*i +: 4]),
            .borrow_out (borrow[i+1]),
            .is_zero    (zero[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        prog_d     = prog_q;
        count_load = 1'b0;
        load_val   = prog_q;
        dec_en     = 1'b0;
        pulse_d    = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.prog_load) begin
                    prog_d     = clamped;
                    load_val   = clamped;
                    count_load = 1'b1;
                end else if (bus.clear) begin
                    count_load = 1'b1;
                end else if (bus.start && (prog_q != '0)) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end

            ST_RUN: begin
                if (bus.clear) begin
                    state_d    = ST_IDLE;
                    presc_d    = '0;
                    count_load = 1'b1;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (bus.start) begin
                        state_d = ST_PAUSE;
                    end
                    if (tick) begin
                        dec_en  = 1'b1;
                        pulse_d = 1'b1;
                        // Expiry takes precedence over a coincident pause request.
                        if (last_sec) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            dec_en     = 1'b0;
                            count_load = 1'b1;
                            done_d     = 1'b1;
`else
                            state_d    = ST_DONE;
`endif
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (bus.clear) begin
                    state_d    = ST_IDLE;
                    presc_d    = '0;
                    count_load = 1'b1;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                if (bus.clear || bus.start) begin
                    state_d    = ST_IDLE;
                    presc_d    = '0;
                    count_load = 1'b1;
                end
            end
        endcase

        running_d = (state_d == ST_RUN);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        done_d    = (state_d == ST_DONE);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            prog_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            prog_q    <= prog_d;
            running_q <= running_d;
            done_q    <= done_d;
            pulse_q   <= pulse_d;
        end
    end

    assign bus.count_bcd = count;
    assign bus.state     = state_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.sec_pulse = pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer (4 digits, mm:ss, 4 clocks per second).
// Honours COUNTDOWN_AUTO_RELOAD_EN the same way as the RTL.
module tb_countdown_timer;
    import countdown_pkg::*;

    localparam int ND  = 4;
    localparam int TPS = 4;
    localparam int PW  = 3;
    localparam int MM  = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    countdown_timer_if #(.NUM_DIGITS(ND)) bus ();

    countdown_timer #(
        .NUM_DIGITS    (ND),
        .TICKS_PER_SEC (TPS),
        .PRESCALE_W    (PW),
        .MMSS_MODE     (MM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [15:0] val);
        bus.prog_bcd  = val;
        bus.prog_load = 1'b1;
        step(1);
        bus.prog_load = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.clear     = 1'b0;
        bus.prog_load = 1'b0;
        bus.prog_bcd  = '0;

        // Reset state
        step(2);
        check("rst_state", bus.state, ST_IDLE);
        check("rst_count", bus.count_bcd, 16'h0000);
        check("rst_running", bus.running, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_sec", bus.sec_pulse, 1'b0);
        #2 reset = 1'b1;
        step(1);

        // 01:02 countdown
        load(16'h0102);
        check("load_0102", bus.count_bcd, 16'h0102);
        pulse_start();
        check("run_state", bus.state, ST_RUN);
        check("run_running", bus.running, 1'b1);
        step(3);
        check("pre_tick_count", bus.count_bcd, 16'h0102);
        check("pre_tick_sec", bus.sec_pulse, 1'b0);
        step(1);
        check("tick1_count", bus.count_bcd, 16'h0101);
        check("tick1_sec", bus.sec_pulse, 1'b1);
        step(1);
        check("tick1_sec_low", bus.sec_pulse, 1'b0);
        step(3);
        check("tick2_count", bus.count_bcd, 16'h0100);
        step(4);
        check("tick3_borrow", bus.count_bcd, 16'h0059);
        step(4);
        check("tick4_count", bus.count_bcd, 16'h0058);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        step(231);
        check("last_sec_count", bus.count_bcd, 16'h0001);
        check("last_sec_state", bus.state, ST_RUN);
        step(1);
        check("done_state", bus.state, ST_DONE);
        check("done_flag", bus.done, 1'b1);
        check("done_count", bus.count_bcd, 16'h0000);
        check("done_running", bus.running, 1'b0);
        step(10);
        check("done_hold_count", bus.count_bcd, 16'h0000);
        check("done_hold_flag", bus.done, 1'b1);
        pulse_start();
        check("rerun_state", bus.state, ST_IDLE);
        check("rerun_count", bus.count_bcd, 16'h0102);
        check("rerun_done", bus.done, 1'b0);
`else
        pulse_clear();
        check("clr_state", bus.state, ST_IDLE);
`endif

        // Pause and resume without losing prescaler progress
        load(16'h0010);
        pulse_start();
        step(1);
        pulse_start();
        check("pause_state", bus.state, ST_PAUSE);
        check("pause_running", bus.running, 1'b0);
        step(20);
        check("pause_hold_count", bus.count_bcd, 16'h0010);
        check("pause_hold_state", bus.state, ST_PAUSE);
        pulse_start();
        check("resume_state", bus.state, ST_RUN);
        step(1);
        check("resume_p1_count", bus.count_bcd, 16'h0010);
        step(1);
        check("resume_p2_count", bus.count_bcd, 16'h0009);
        check("resume_p2_sec", bus.sec_pulse, 1'b1);

        // start and clear together in RUN: clear wins and reloads
        bus.start = 1'b1;
        bus.clear = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.clear = 1'b0;
        check("stclr_state", bus.state, ST_IDLE);
        check("stclr_count", bus.count_bcd, 16'h0010);
        check("stclr_running", bus.running, 1'b0);

        // clear on the tick cycle: no decrement
        pulse_start();
        step(3);
        pulse_clear();
        check("tickclr_sec", bus.sec_pulse, 1'b0);
        check("tickclr_state", bus.state, ST_IDLE);
        check("tickclr_count", bus.count_bcd, 16'h0010);

        // prog_load with start in IDLE: load applied, start ignored
        bus.prog_bcd  = 16'h0030;
        bus.prog_load = 1'b1;
        bus.start     = 1'b1;
        step(1);
        bus.prog_load = 1'b0;
        bus.start     = 1'b0;
        check("ldst_state", bus.state, ST_IDLE);
        check("ldst_count", bus.count_bcd, 16'h0030);

        // Digit clamping and zero-time start
        load(16'h9F7A);
        check("clamp_count", bus.count_bcd, 16'h5959);
        load(16'h0000);
        pulse_start();
        check("zero_start_state", bus.state, ST_IDLE);
        check("zero_start_running", bus.running, 1'b0);

        // Asynchronous reset in the middle of RUN
        load(16'h0042);
        pulse_start();
        step(2);
        reset = 1'b0;
        #2;
        check("arst_state", bus.state, ST_IDLE);
        check("arst_count", bus.count_bcd, 16'h0000);
        check("arst_running", bus.running, 1'b0);
        check("arst_done", bus.done, 1'b0);
        check("arst_sec", bus.sec_pulse, 1'b0);
        reset = 1'b1;
        step(1);
        pulse_start();
        check("arst_prog_lost", bus.state, ST_IDLE);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Periodic reload: done pulses every 8 cycles, never enters DONE
        load(16'h0002);
        pulse_start();
        for (int p = 1; p <= 3; p++) begin
            step(4);
            check("auto_mid_count", bus.count_bcd, 16'h0001);
            check("auto_mid_done", bus.done, 1'b0);
            step(3);
            check("auto_pre_done", bus.done, 1'b0);
            step(1);
            check("auto_done_pulse", bus.done, 1'b1);
            check("auto_state", bus.state, ST_RUN);
            check("auto_reload", bus.count_bcd, 16'h0002);
        end
        step(1);
        check("auto_done_low", bus.done, 1'b0);
        pulse_clear();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
